// File: rtl/fetch_pipe.sv
// fetch_pipe: decoupled instruction-fetch stage. Issues in-order requests from
// the PC, buffers responses with PC/PC+4 in a small queue, and flushes on redirect.
module fetch_pipe #(
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
   parameter int unsigned           QUEUE_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [DATA_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_resp_valid,
   input  logic [DATA_WIDTH-1:0] imem_resp_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_instr,
   output logic [DATA_WIDTH-1:0] out_pc,
   output logic [DATA_WIDTH-1:0] out_pc4
);

   localparam int unsigned           PTR_W      = $clog2(QUEUE_DEPTH);
   localparam int unsigned           CNT_W      = PTR_W + 1;
   localparam logic [CNT_W-1:0]      DEPTH_C    = CNT_W'(QUEUE_DEPTH);
   localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
   localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] pc4;
      logic [DATA_WIDTH-1:0] instr;
   } entry_t;

   state_t                 state;
   logic [DATA_WIDTH-1:0]  pc;
   entry_t                 q_entry [QUEUE_DEPTH];
   logic [QUEUE_DEPTH-1:0] q_filled;
   logic [PTR_W-1:0]       head_ptr;
   logic [PTR_W-1:0]       tail_ptr;
   logic [PTR_W-1:0]       fill_ptr;
   logic [CNT_W-1:0]       count;
   logic [CNT_W-1:0]       pending;
   logic [CNT_W-1:0]       discard;

   logic                   req_ok_c;
   logic                   req_fire_c;
   logic                   pop_c;
   logic                   fill_c;
   logic                   drop_c;
   logic [CNT_W-1:0]       flush_discard_c;
   logic [CNT_W-1:0]       drain_left_c;

   // Handshake qualifiers and flush/drain bookkeeping
   always_comb begin
      req_ok_c        = (state == RUN) && !redirect_valid && (count < DEPTH_C);
      req_fire_c      = req_ok_c && imem_req_ready;
      pop_c           = out_valid && out_ready && !redirect_valid;
      fill_c          = imem_resp_valid && (state == RUN) && (pending != '0);
      drop_c          = imem_resp_valid && (state == DRAIN) && (discard != '0);
      // A response landing in the redirect cycle consumes one of the unfilled slots
      flush_discard_c = pending - CNT_W'(fill_c);
      drain_left_c    = discard - CNT_W'(drop_c);
   end

   assign imem_req_valid = rst && req_ok_c;
   assign imem_req_addr  = pc;
   assign out_valid      = q_filled[head_ptr];
   assign out_instr      = q_entry[head_ptr].instr;
   assign out_pc         = q_entry[head_ptr].pc;
   assign out_pc4        = q_entry[head_ptr].pc4;

   // PC, queue storage and RUN/DRAIN state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= RUN;
         pc       <= RESET_PC;
         head_ptr <= '0;
         tail_ptr <= '0;
         fill_ptr <= '0;
         count    <= '0;
         pending  <= '0;
         discard  <= '0;
         q_filled <= '0;
         for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
            q_entry[i] <= '0;
         end
      end else begin
         if (redirect_valid) begin
            pc       <= redirect_pc & ALIGN_MASK;
            head_ptr <= '0;
            tail_ptr <= '0;
            fill_ptr <= '0;
            count    <= '0;
            pending  <= '0;
            q_filled <= '0;
         end else begin
            if (req_fire_c) begin
               pc                    <= pc + PC_STEP;
               q_entry[tail_ptr].pc  <= pc;
               q_entry[tail_ptr].pc4 <= pc + PC_STEP;
               q_filled[tail_ptr]    <= 1'b0;
               tail_ptr              <= tail_ptr + PTR_W'(1);
            end
            if (fill_c) begin
               q_entry[fill_ptr].instr <= imem_resp_data;
               q_filled[fill_ptr]      <= 1'b1;
               fill_ptr                <= fill_ptr + PTR_W'(1);
            end
            if (pop_c) begin
               q_filled[head_ptr] <= 1'b0;
               head_ptr           <= head_ptr + PTR_W'(1);
            end
            count   <= count + CNT_W'(req_fire_c) - CNT_W'(pop_c);
            pending <= pending + CNT_W'(req_fire_c) - CNT_W'(fill_c);
         end

         if (state == RUN) begin
            if (redirect_valid) begin
               discard <= flush_discard_c;
               state   <= (flush_discard_c != '0) ? DRAIN : RUN;
            end
         end else begin
            // Redirects here leave the count alone; only stale responses retire it
            discard <= drain_left_c;
            if (drain_left_c == '0) begin
               state <= RUN;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_pipe.sv
// tb_fetch_pipe: directed and randomized checks of fetch_pipe against a
// stream-level PC model and an in-order, variable-latency memory.
module tb_fetch_pipe;

   localparam int          DW       = 32;
   localparam int          QD       = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc4;

   always #5 clk = ~clk;

   fetch_pipe #(
      .DATA_WIDTH (DW),
      .RESET_PC   (RESET_PC),
      .QUEUE_DEPTH(QD)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data (imem_resp_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_pc4        (out_pc4)
   );

   int          n_cmp;
   int          n_err;
   int unsigned cyc;
   int          ready_pct;
   int          out_pct;
   int unsigned lat_min;
   int unsigned lat_max;
   logic [31:0] req_pc_m;
   logic [31:0] out_pc_m;
   int          occ_m;
   int          n_req;
   int          n_pop;
   logic [31:0] mq_addr [$];
   int unsigned mq_due  [$];
   logic [31:0] pop_log [$];
   logic        s_req_valid;
   logic        s_out_valid;
   logic [31:0] s_req_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] pop_at(input int j);
      return (pop_log.size() > j) ? pop_log[j] : 32'hFFFF_FFFF;
   endfunction

   task automatic set_knobs(input int rp, input int op, input int unsigned lmin, input int unsigned lmax);
      ready_pct = rp;
      out_pct   = op;
      lat_min   = lmin;
      lat_max   = lmax;
   endtask

   task automatic do_reset();
      rst             = 1'b0;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      mq_addr.delete();
      mq_due.delete();
      pop_log.delete();
      req_pc_m = RESET_PC;
      out_pc_m = RESET_PC;
      occ_m    = 0;
      n_req    = 0;
      n_pop    = 0;
      repeat (2) @(posedge clk);
      #1;
      imem_req_ready = int'($urandom_range(99)) < ready_pct;
      out_ready      = int'($urandom_range(99)) < out_pct;
      rst            = 1'b1;
   endtask

   // One clock: sample at negedge, update model at posedge, drive memory and readies after
   task automatic tick();
      logic        req_fire;
      logic        out_fire;
      int unsigned due;
      @(negedge clk);
      s_req_valid = imem_req_valid;
      s_req_addr  = imem_req_addr;
      s_out_valid = out_valid;
      req_fire    = imem_req_valid && imem_req_ready;
      out_fire    = out_valid && out_ready && !redirect_valid;
      n_cmp++;
      if (imem_req_addr !== req_pc_m) begin
         n_err++;
         $display("FAIL req_addr @%0d: got %h expected %h", cyc, imem_req_addr, req_pc_m);
      end
      if (occ_m >= QD || redirect_valid) begin
         n_cmp++;
         if (imem_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL req_blocked @%0d: got %b expected 0 (occ %0d redirect %b)",
                     cyc, imem_req_valid, occ_m, redirect_valid);
         end
      end
      if (out_fire) begin
         n_cmp++;
         if (out_pc !== out_pc_m) begin
            n_err++;
            $display("FAIL out_pc @%0d: got %h expected %h", cyc, out_pc, out_pc_m);
         end
         n_cmp++;
         if (out_instr !== mem_word(out_pc_m)) begin
            n_err++;
            $display("FAIL out_instr @%0d: got %h expected %h", cyc, out_instr, mem_word(out_pc_m));
         end
         n_cmp++;
         if (out_pc4 !== out_pc_m + 32'd4) begin
            n_err++;
            $display("FAIL out_pc4 @%0d: got %h expected %h", cyc, out_pc4, out_pc_m + 32'd4);
         end
         pop_log.push_back(out_pc);
      end
      @(posedge clk);
      cyc++;
      if (redirect_valid) begin
         req_pc_m = redirect_pc & ~32'd3;
         out_pc_m = redirect_pc & ~32'd3;
         occ_m    = 0;
      end else begin
         if (req_fire) begin
            req_pc_m += 32'd4;
            occ_m++;
            n_req++;
         end
         if (out_fire) begin
            out_pc_m += 32'd4;
            occ_m--;
            n_pop++;
         end
      end
      if (req_fire) begin
         due = cyc + $urandom_range(lat_max, lat_min) - 1;
         if (mq_due.size() != 0 && due < mq_due[$]) due = mq_due[$];
         mq_due.push_back(due);
         mq_addr.push_back(s_req_addr);
      end
      #1;
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      if (mq_due.size() != 0 && mq_due[0] <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_word(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end
      imem_req_ready = int'($urandom_range(99)) < ready_pct;
      out_ready      = int'($urandom_range(99)) < out_pct;
   endtask

   task automatic test_reset();
      set_knobs(100, 100, 1, 1);
      rst = 1'b0;
      #1;
      n_cmp++;
      if (imem_req_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid);
      end
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      n_cmp++;
      if (imem_req_addr !== RESET_PC) begin
         n_err++; $display("FAIL reset_addr: got %h expected %h", imem_req_addr, RESET_PC);
      end
      do_reset();
      tick();
      n_cmp++;
      if (s_req_valid !== 1'b1) begin
         n_err++; $display("FAIL first_req_valid: got %b expected 1", s_req_valid);
      end
   endtask

   task automatic test_stream();
      set_knobs(100, 100, 1, 1);
      do_reset();
      for (int k = 0; k < 12; k++) begin
         tick();
         n_cmp++;
         if (s_out_valid !== (k >= 2)) begin
            n_err++; $display("FAIL stream_out_valid tick %0d: got %b expected %b", k, s_out_valid, (k >= 2));
         end
      end
      n_cmp++;
      if (n_pop !== 10) begin
         n_err++; $display("FAIL stream_pops: got %0d expected 10", n_pop);
      end
      for (int j = 0; j < 10; j++) begin
         n_cmp++;
         if (pop_at(j) !== 32'(4 * j)) begin
            n_err++; $display("FAIL stream_order %0d: got %h expected %h", j, pop_at(j), 32'(4 * j));
         end
      end
   endtask

   task automatic test_full();
      set_knobs(100, 0, 1, 1);
      do_reset();
      repeat (8) tick();
      n_cmp++;
      if (n_req !== QD) begin
         n_err++; $display("FAIL full_req_count: got %0d expected %0d", n_req, QD);
      end
      n_cmp++;
      if (s_req_valid !== 1'b0) begin
         n_err++; $display("FAIL full_req_valid: got %b expected 0", s_req_valid);
      end
      out_pct   = 100;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && n_pop < 4; i++) tick();
      n_cmp++;
      if (n_pop < 4) begin
         n_err++; $display("FAIL full_drain_timeout: got %0d pops expected 4", n_pop);
      end
      for (int j = 0; j < 4; j++) begin
         n_cmp++;
         if (pop_at(j) !== 32'(4 * j)) begin
            n_err++; $display("FAIL full_order %0d: got %h expected %h", j, pop_at(j), 32'(4 * j));
         end
      end
   endtask

   task automatic test_redirect_drain();
      set_knobs(100, 100, 3, 3);
      do_reset();
      tick();
      tick();
      ready_pct      = 0;
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      tick();
      redirect_valid = 1'b0;
      ready_pct      = 100;
      imem_req_ready = 1'b1;
      pop_log.delete();
      for (int k = 0; k < 2; k++) begin
         tick();
         n_cmp++;
         if (s_req_valid !== 1'b0 || s_out_valid !== 1'b0) begin
            n_err++; $display("FAIL drain_quiet tick %0d: got req %b out %b expected 0 0", k, s_req_valid, s_out_valid);
         end
      end
      tick();
      n_cmp++;
      if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0000_0200) begin
         n_err++; $display("FAIL drain_resume: got valid %b addr %h expected 1 00000200", s_req_valid, s_req_addr);
      end
      for (int i = 0; i < 20 && pop_log.size() == 0; i++) tick();
      n_cmp++;
      if (pop_at(0) !== 32'h0000_0200) begin
         n_err++; $display("FAIL drain_first_pop: got %h expected 00000200", pop_at(0));
      end
   endtask

   task automatic test_redirect_nodrain();
      set_knobs(0, 100, 1, 1);
      do_reset();
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      tick();
      redirect_valid = 1'b0;
      ready_pct      = 100;
      imem_req_ready = 1'b1;
      tick();
      n_cmp++;
      if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0000_0100) begin
         n_err++; $display("FAIL nodrain_req: got valid %b addr %h expected 1 00000100", s_req_valid, s_req_addr);
      end
      for (int i = 0; i < 10 && pop_log.size() == 0; i++) tick();
      n_cmp++;
      if (pop_at(0) !== 32'h0000_0100) begin
         n_err++; $display("FAIL nodrain_first_pop: got %h expected 00000100", pop_at(0));
      end
   endtask

   task automatic test_backpressure();
      set_knobs(100, 100, 1, 1);
      do_reset();
      repeat (3) tick();
      ready_pct      = 0;
      imem_req_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_cmp++;
         if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0000_000C) begin
            n_err++; $display("FAIL stall_hold tick %0d: got valid %b addr %h expected 1 0000000c", k, s_req_valid, s_req_addr);
         end
      end
      ready_pct      = 100;
      imem_req_ready = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (s_req_addr !== 32'h0000_0010) begin
         n_err++; $display("FAIL stall_advance: got %h expected 00000010", s_req_addr);
      end
   endtask

   task automatic test_async_reset();
      set_knobs(100, 0, 1, 1);
      do_reset();
      tick();
      tick();
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_err++; $display("FAIL async_precond_out_valid: got %b expected 1", out_valid);
      end
      #2;
      rst = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
         n_err++; $display("FAIL async_reset_outputs: got out %b req %b expected 0 0", out_valid, imem_req_valid);
      end
      set_knobs(100, 100, 1, 1);
      do_reset();
      repeat (8) tick();
      n_cmp++;
      if (pop_at(0) !== RESET_PC) begin
         n_err++; $display("FAIL async_restart_pc: got %h expected %h", pop_at(0), RESET_PC);
      end
   endtask

   task automatic test_random();
      set_knobs(70, 60, 1, 4);
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(99) < 3) begin
            redirect_valid = 1'b1;
            if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            else                        redirect_pc = $urandom;
         end else begin
            redirect_valid = 1'b0;
         end
         if ($urandom_range(99) < 2) out_pct = int'($urandom_range(100));
         tick();
      end
      redirect_valid = 1'b0;
      n_cmp++;
      if (n_pop < 100) begin
         n_err++; $display("FAIL random_progress: got %0d pops expected at least 100", n_pop);
      end
   endtask

   initial begin
      n_cmp          = 0;
      n_err          = 0;
      cyc            = 0;
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data = '0;
      out_ready      = 1'b0;
      set_knobs(100, 100, 1, 1);
      #2;
      test_reset();
      test_stream();
      test_full();
      test_redirect_drain();
      test_redirect_nodrain();
      test_backpressure();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      n_err++;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog expired");
   end

endmodule
